// File: rtl/router_tx_engine.sv
// Aurora TX packet engine: sends one header beat followed by BEATS payload
// beats read from BRAM, with link-loss abort and busy/link-down rejection.
module router_tx_engine #(
  parameter int DATA_W = 256,
  parameter int BEATS  = 4
) (
  input  logic              user_clk,
  input  logic              reset,
  input  logic              channel_up,
  input  logic              router_start_req,
  input  logic [9:0]        router_scr_addr,
  input  logic [9:0]        router_dst_addr,
  output logic              bram_en,
  output logic [11:0]       bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_axis_tx_tdata,
  output logic              m_axis_tx_tvalid,
  output logic              m_axis_tx_tlast,
  input  logic              m_axis_tx_tready,
  output logic              router_done,
  output logic              router_err,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, HDR, RD, CAP, SEND, DONE} state_t;

  state_t     state, next;
  logic [9:0] src, dst;
  logic [1:0] beat;
  logic       hs, active, last_beat, start_ok;

  assign hs        = m_axis_tx_tvalid & m_axis_tx_tready;
  assign active    = (state == HDR) || (state == RD) || (state == CAP) || (state == SEND);
  assign last_beat = (beat == 2'(BEATS - 1));
  assign start_ok  = router_start_req & channel_up;

  assign bram_en     = (state == RD);
  assign bram_addr   = {src, beat};
  assign router_done = (state == DONE);
  assign busy        = (state != IDLE);

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start_ok) next = HDR;
      HDR:     if (hs) next = RD;
      RD:      next = CAP;
      CAP:     next = SEND;
      SEND:    if (hs) next = m_axis_tx_tlast ? DONE : RD;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
    if (active && !channel_up) next = IDLE;
  end

  always_ff @(posedge user_clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      src              <= '0;
      dst              <= '0;
      beat             <= '0;
      m_axis_tx_tdata  <= '0;
      m_axis_tx_tvalid <= 1'b0;
      m_axis_tx_tlast  <= 1'b0;
      router_err       <= 1'b0;
    end else begin
      router_err <= (router_start_req && (busy || !channel_up)) || (active && !channel_up);
      case (state)
        IDLE: if (start_ok) begin
          src              <= router_scr_addr;
          dst              <= router_dst_addr;
          beat             <= '0;
          m_axis_tx_tdata  <= {{(DATA_W-28){1'b0}}, 6'd0, 2'(BEATS - 1),
                               router_scr_addr, router_dst_addr};
          m_axis_tx_tvalid <= 1'b1;
          m_axis_tx_tlast  <= 1'b0;
        end
        HDR: if (hs) m_axis_tx_tvalid <= 1'b0;
        CAP: begin
          m_axis_tx_tdata  <= bram_dout;
          m_axis_tx_tvalid <= 1'b1;
          m_axis_tx_tlast  <= last_beat;
        end
        SEND: if (hs) begin
          m_axis_tx_tvalid <= 1'b0;
          m_axis_tx_tlast  <= 1'b0;
          if (!m_axis_tx_tlast) beat <= beat + 2'd1;
        end
        default: ;
      endcase
      // Link loss overrides whatever the state would have driven this cycle.
      if (active && !channel_up) begin
        m_axis_tx_tvalid <= 1'b0;
        m_axis_tx_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_tx_engine.sv
// Directed bench for router_tx_engine: nominal packet, backpressure, busy and
// link-down rejection, link loss mid-packet and reset mid-packet.
module tb_router_tx_engine;
  localparam int DATA_W = 256;
  localparam int BEATS  = 4;

  logic              user_clk = 1'b0;
  logic              reset = 1'b1;
  logic              channel_up = 1'b0;
  logic              router_start_req = 1'b0;
  logic [9:0]        router_scr_addr = '0;
  logic [9:0]        router_dst_addr = '0;
  logic              bram_en;
  logic [11:0]       bram_addr;
  logic [DATA_W-1:0] bram_dout = '0;
  logic [DATA_W-1:0] m_axis_tx_tdata;
  logic              m_axis_tx_tvalid;
  logic              m_axis_tx_tlast;
  logic              m_axis_tx_tready = 1'b0;
  logic              router_done;
  logic              router_err;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;
  int beat_cnt = 0, done_cnt = 0, err_cnt = 0, en_cnt = 0;

  router_tx_engine #(.DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .user_clk(user_clk), .reset(reset), .channel_up(channel_up),
    .router_start_req(router_start_req), .router_scr_addr(router_scr_addr),
    .router_dst_addr(router_dst_addr), .bram_en(bram_en), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .m_axis_tx_tdata(m_axis_tx_tdata),
    .m_axis_tx_tvalid(m_axis_tx_tvalid), .m_axis_tx_tlast(m_axis_tx_tlast),
    .m_axis_tx_tready(m_axis_tx_tready), .router_done(router_done),
    .router_err(router_err), .busy(busy)
  );

  always #5 user_clk = ~user_clk;

  // BRAM word k of a block holds k+1
  always @(posedge user_clk)
    if (bram_en) bram_dout <= 256'(bram_addr[1:0]) + 256'd1;

  always @(negedge user_clk) begin
    if (m_axis_tx_tvalid && m_axis_tx_tready) beat_cnt++;
    if (router_done) done_cnt++;
    if (router_err)  err_cnt++;
    if (bram_en)     en_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic run_packet(input logic [9:0] s, input logic [9:0] d, input int stall_beat,
                            input int stall_len, input int busy_beat, input int drop_beat);
    int b0, d0, e0;
    bit dropped;
    logic [255:0] hdr;
    dropped = 1'b0;
    b0 = beat_cnt; d0 = done_cnt; e0 = err_cnt;
    hdr = (256'(BEATS - 1) << 20) | (256'(s) << 10) | 256'(d);
    router_scr_addr = s; router_dst_addr = d;
    router_start_req = 1'b1; m_axis_tx_tready = 1'b1;
    tick();
    router_start_req = 1'b0; router_scr_addr = '0; router_dst_addr = '0;
    check("hdr_valid", 256'(m_axis_tx_tvalid), 256'd1);
    check("hdr_data", m_axis_tx_tdata, hdr);
    check("hdr_last", 256'(m_axis_tx_tlast), 256'd0);
    check("hdr_busy", 256'(busy), 256'd1);
    tick();
    for (int k = 0; k < BEATS; k++) begin
      check("rd_en", 256'(bram_en), 256'd1);
      check("rd_addr", 256'(bram_addr), 256'({s, 2'(k)}));
      if (k == stall_beat) m_axis_tx_tready = 1'b0;
      tick();
      check("cap_valid", 256'(m_axis_tx_tvalid), 256'd0);
      tick();
      check("pay_valid", 256'(m_axis_tx_tvalid), 256'd1);
      check("pay_data", m_axis_tx_tdata, 256'(k + 1));
      check("pay_last", 256'(m_axis_tx_tlast), 256'(k == BEATS - 1));
      if (k == drop_beat) begin
        channel_up = 1'b0; m_axis_tx_tready = 1'b0;
        tick();
        check("drop_valid", 256'(m_axis_tx_tvalid), 256'd0);
        check("drop_err", 256'(router_err), 256'd1);
        check("drop_busy", 256'(busy), 256'd0);
        tick();
        check("drop_err_clr", 256'(router_err), 256'd0);
        channel_up = 1'b1; m_axis_tx_tready = 1'b1;
        dropped = 1'b1;
        break;
      end
      if (k == stall_beat) begin
        for (int i = 0; i < stall_len - 1; i++) begin
          tick();
          check("stall_valid", 256'(m_axis_tx_tvalid), 256'd1);
          check("stall_data", m_axis_tx_tdata, 256'(k + 1));
          check("stall_last", 256'(m_axis_tx_tlast), 256'(k == BEATS - 1));
        end
        m_axis_tx_tready = 1'b1;
      end
      if (k == busy_beat) begin
        router_start_req = 1'b1; router_scr_addr = 10'h001; router_dst_addr = 10'h002;
      end
      tick();
      if (k == busy_beat) begin
        router_start_req = 1'b0; router_scr_addr = '0; router_dst_addr = '0;
        check("busy_err", 256'(router_err), 256'd1);
      end
    end
    if (!dropped) begin
      check("done_pulse", 256'(router_done), 256'd1);
      check("done_valid", 256'(m_axis_tx_tvalid), 256'd0);
      tick();
      check("done_clr", 256'(router_done), 256'd0);
      check("idle_busy", 256'(busy), 256'd0);
      check("beat_total", 256'(beat_cnt - b0), 256'(BEATS + 1));
      check("done_total", 256'(done_cnt - d0), 256'd1);
      check("err_total", 256'(err_cnt - e0), 256'(busy_beat >= 0));
    end else begin
      check("drop_beats", 256'(beat_cnt - b0), 256'(drop_beat + 1));
      check("drop_done", 256'(done_cnt - d0), 256'd0);
      check("drop_errs", 256'(err_cnt - e0), 256'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 256'(m_axis_tx_tvalid), 256'd0);
    check({tag, "_last"}, 256'(m_axis_tx_tlast), 256'd0);
    check({tag, "_en"}, 256'(bram_en), 256'd0);
    check({tag, "_done"}, 256'(router_done), 256'd0);
    check({tag, "_err"}, 256'(router_err), 256'd0);
    check({tag, "_busy"}, 256'(busy), 256'd0);
    check({tag, "_data"}, m_axis_tx_tdata, 256'd0);
    check({tag, "_addr"}, 256'(bram_addr), 256'd0);
  endtask

  initial begin
    int e0, n0;
    tick(); tick();
    check_reset_outputs("rst");
    reset = 1'b0; channel_up = 1'b1;
    tick();

    run_packet(10'h005, 10'h00F, -1, 0, -1, -1);
    run_packet(10'h005, 10'h00F, 1, 5, -1, -1);
    run_packet(10'h005, 10'h00F, -1, 0, 1, -1);
    run_packet(10'h005, 10'h00F, -1, 0, -1, 2);
    run_packet(10'h3FF, 10'h2C1, -1, 0, BEATS - 1, -1);

    // start with the link down
    e0 = err_cnt; n0 = en_cnt;
    channel_up = 1'b0; router_start_req = 1'b1; router_scr_addr = 10'h005;
    tick();
    router_start_req = 1'b0;
    check("ldn_err", 256'(router_err), 256'd1);
    check("ldn_busy", 256'(busy), 256'd0);
    check("ldn_valid", 256'(m_axis_tx_tvalid), 256'd0);
    tick(); tick();
    check("ldn_err_clr", 256'(router_err), 256'd0);
    check("ldn_busy2", 256'(busy), 256'd0);
    check("ldn_errs", 256'(err_cnt - e0), 256'd1);
    check("ldn_no_rd", 256'(en_cnt - n0), 256'd0);
    channel_up = 1'b1;
    tick();

    // reset while in CAP
    router_scr_addr = 10'h007; router_dst_addr = 10'h009; router_start_req = 1'b1;
    m_axis_tx_tready = 1'b1;
    tick();
    router_start_req = 1'b0;
    tick(); tick();
    check("cap_state_en", 256'(bram_en), 256'd0);
    reset = 1'b1;
    tick();
    check_reset_outputs("mid_rst");
    reset = 1'b0;
    run_packet(10'h0A5, 10'h15A, -1, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_tx_engine.md
ROUTER_TX_ENGINE -- requirements
Module: router_tx_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 256, Aurora TX user-data width in bits.
REQ-002 SHALL have parameter BEATS, default 4, payload beats per packet (1024 bits / DATA_W).
REQ-003 SHALL have port user_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port channel_up  input  1  Aurora link ready.
REQ-006 SHALL have port router_start_req  input  1  one-cycle request pulse.
REQ-007 SHALL have port router_scr_addr  input  10  source block index, sampled with start.
REQ-008 SHALL have port router_dst_addr  input  10  destination node address, sampled with start.
REQ-009 SHALL have port bram_en  output  1  payload BRAM read enable.
REQ-010 SHALL have port bram_addr  output  12  BRAM word address = {src, beat[1:0]}.
REQ-011 SHALL have port bram_dout  input  DATA_W  BRAM read data, valid one cycle after bram_en.
REQ-012 SHALL have ports m_axis_tx_tdata (output, DATA_W), m_axis_tx_tvalid (output, 1), m_axis_tx_tlast (output, 1), m_axis_tx_tready (input, 1)  AXI-Stream to Aurora TX.
REQ-013 SHALL have port router_done  output  1  one-cycle pulse, packet fully accepted.
REQ-014 SHALL have port router_err  output  1  one-cycle pulse, request dropped or packet aborted.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, HDR, RD, CAP, SEND, DONE.
REQ-017 IDLE: start with channel_up=1 SHALL latch src/dst, clear beat counter, go HDR; start with channel_up=0 SHALL pulse router_err next cycle, stay IDLE.
REQ-018 HDR: SHALL drive tvalid=1, tlast=0, tdata = {zeros, 6'd0, 2'(BEATS-1), src[9:0], dst[9:0]} (dst in bits 9:0); go RD on tvalid&tready.
REQ-019 RD: SHALL assert bram_en=1 for exactly one cycle with bram_addr={src, beat}; go CAP.
REQ-020 CAP: SHALL register bram_dout into tdata, set tvalid=1, tlast=(beat==BEATS-1); go SEND.
REQ-021 SEND: SHALL hold tdata/tvalid/tlast stable until tready; on handshake, if tlast go DONE, else beat+1 and go RD.
REQ-022 DONE: SHALL pulse router_done for one cycle, deassert tvalid, return IDLE.
REQ-023 Header beat to first payload tvalid SHALL take 2 cycles after header handshake; start to header tvalid SHALL take 1 cycle.
REQ-024 router_start_req while busy=1 SHALL be ignored and SHALL pulse router_err next cycle; latched addresses unchanged.
REQ-025 channel_up falling in HDR/RD/CAP/SEND SHALL drop tvalid next cycle, pulse router_err, go IDLE; router_done not asserted.
REQ-026 Beat counter SHALL be 2 bits and never wrap within a packet; packet = 1 header + BEATS payload beats exactly.
REQ-027 tready with tvalid=0 SHALL have no effect; tready held high SHALL yield one payload beat per 3 cycles.

Reset
REQ-028 Reset SHALL force IDLE; tvalid, tlast, bram_en, router_done, router_err, busy = 0; tdata, bram_addr, latched addresses, beat = 0.
REQ-029 Reset mid-packet SHALL abort without router_done/router_err pulse; first cycle after reset deassert SHALL accept a new start.

Verification
REQ-030 Nominal: channel_up=1, tready=1, start src=0x005 dst=0x00F, BRAM word k=k+1 -> header dst=0x00F src=0x005, payloads 1,2,3,4, tlast on beat 4, bram_addr 0x014..0x017, router_done one cycle after last handshake.
REQ-031 Backpressure: tready low 5 cycles at payload beat 2 -> tdata/tlast stable throughout, exactly 5 beats total, single router_done.
REQ-032 Busy start: second start (src=0x001) during SEND -> router_err pulse, packet still carries src=0x005, one router_done.
REQ-033 Link drop: channel_up=0 during beat 3 SEND -> tvalid low next cycle, router_err pulse, no router_done, next start succeeds.
REQ-034 Link down start: channel_up=0, start -> router_err pulse, bram_en never asserted, busy stays 0.
REQ-035 Reset mid-packet: reset during CAP -> all outputs at REQ-028 values next cycle, no pulses.
